// File: rtl/core_sequencer_pkg.sv
// Shared phase encodings and defaults for the sequencer, register file, ALU and LSU.
// Optional build macro used by core_sequencer: SEQ_PERF_CNT_EN.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH         = 3'd0,
        ST_DECODE        = 3'd1,
        ST_REG_FILE_READ = 3'd2,
        ST_EXECUTE       = 3'd3,
        ST_MEM_ACCESS    = 3'd4,
        ST_WRITE_BACK    = 3'd5,
        ST_HALT          = 3'd6,
        ST_UNUSED        = 3'd7
    } seq_state_e;

    localparam int BUS_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF       = 32;

    // Phases in which the sequencer holds a bus request and waits for an ack.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_ACCESS);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Purpose: counts cycles spent waiting on a bus ack and flags the timeout.
// Latency: expired is combinational from the registered count (asserts in the TIMEOUT-th wait cycle).
// Backpressure: none; clr has priority over en, and the count saturates. TIMEOUT=0 never expires.
module seq_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int  MAX_CNT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int  CW      = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;
    localparam logic ACTIVE = (TIMEOUT > 0);

    logic [CW-1:0] cnt;
    logic          at_max;

    assign at_max = (cnt == CW'(MAX_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The count holds the number of wait cycles already completed, so the
    // TIMEOUT-th cycle is the one that sees at_max.
    assign expired = ACTIVE && en && at_max;

endmodule

// File: rtl/core_sequencer.sv
// Purpose: multi-cycle control FSM of the RV32 core; drives the phase bus, bus requests and write gates.
// Latency: ALU instruction 5 cycles ack-to-ack minimum, memory instruction 6; requests held until ack.
// Backpressure: waits indefinitely on imem/dmem ack unless BUS_TIMEOUT expires; optional SEQ_PERF_CNT_EN counters.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    output logic [2:0]       state,
    output logic             ir_we,
    output logic             pc_we,
    output logic             retire,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired_cnt
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    seq_state_e cur_state;
    seq_state_e nxt_state;

    logic in_wait;
    logic wait_ack;
    logic expired;
    logic timeout_hit;

    assign in_wait     = is_wait_state(cur_state);
    assign wait_ack    = ((cur_state == ST_FETCH) && imem_ack) ||
                         ((cur_state == ST_MEM_ACCESS) && dmem_ack);
    // An ack arriving in the expiry cycle completes the access instead of erroring.
    assign timeout_hit = expired && !wait_ack;

    seq_wait_timer #(
        .TIMEOUT (BUS_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = ST_HALT;
        unique case (cur_state)
            ST_FETCH: begin
                if (imem_ack)         nxt_state = ST_DECODE;
                else if (timeout_hit) nxt_state = ST_HALT;
                else                  nxt_state = ST_FETCH;
            end
            ST_DECODE:        nxt_state = is_halt ? ST_HALT : ST_REG_FILE_READ;
            ST_REG_FILE_READ: nxt_state = ST_EXECUTE;
            ST_EXECUTE:       nxt_state = (is_load || is_store) ? ST_MEM_ACCESS : ST_WRITE_BACK;
            ST_MEM_ACCESS: begin
                if (dmem_ack)         nxt_state = ST_WRITE_BACK;
                else if (timeout_hit) nxt_state = ST_HALT;
                else                  nxt_state = ST_MEM_ACCESS;
            end
            ST_WRITE_BACK:    nxt_state = ST_FETCH;
            ST_HALT:          nxt_state = ST_HALT;
            default:          nxt_state = ST_HALT;
        endcase
    end

    // Requests are masked by rst so an in-flight access drops the moment reset asserts.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        unique case (cur_state)
            ST_FETCH: begin
                imem_req = !rst;
                ir_we    = !rst && imem_ack;
            end
            ST_MEM_ACCESS: dmem_req = !rst;
            ST_WRITE_BACK: begin
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            ST_HALT:       halted = 1'b1;
            default: ;
        endcase
    end

    assign state = cur_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (timeout_hit) begin
            bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic stall;

    assign stall = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (cur_state != ST_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (stall)                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer (BUS_TIMEOUT=4, CNT_W=4); inputs driven and outputs sampled around the falling edge.
module tb_core_sequencer;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_ack;
    logic       is_load;
    logic       is_store;
    logic       is_halt;
    logic [2:0] state;
    logic       ir_we;
    logic       pc_we;
    logic       retire;
    logic       halted;
    logic       bus_err;
    logic [3:0] retired_cnt;
`ifdef SEQ_PERF_CNT_EN
    logic [3:0] cycle_cnt;
    logic [3:0] stall_cnt;
`endif

    int n_vec;
    int n_err;
    int exp_retired;
    int exp_cycles;
    int exp_stall;

    core_sequencer #(
        .BUS_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .dmem_req    (dmem_req),
        .dmem_ack    (dmem_ack),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_halt     (is_halt),
        .state       (state),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .retire      (retire),
        .halted      (halted),
        .bus_err     (bus_err),
        .retired_cnt (retired_cnt)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. df/dd = cycles of req before the ack.
    task automatic run_instr(input int df, input int kind, input int dd);
        int exp_st[$];
        logic fa;
        logic da;
        exp_st = {};
        for (int f = 0; f <= df; f++) exp_st.push_back(0);
        exp_st.push_back(1);
        exp_st.push_back(2);
        exp_st.push_back(3);
        if (kind != 0) for (int m = 0; m <= dd; m++) exp_st.push_back(4);
        exp_st.push_back(5);
        is_load  = (kind == 1);
        is_store = (kind == 2);
        is_halt  = 1'b0;
        for (int i = 0; i < exp_st.size(); i++) begin
            fa = (i == df);
            da = (kind != 0) && (i == df + 4 + dd);
            imem_ack = fa;
            dmem_ack = da;
            #1;
            check_val("state", 32'(state), 32'(exp_st[i]));
            check_val("imem_req", 32'(imem_req), 32'(exp_st[i] == 0));
            check_val("dmem_req", 32'(dmem_req), 32'(exp_st[i] == 4));
            check_val("ir_we", 32'(ir_we), 32'(fa));
            check_val("retire", 32'(retire), 32'(exp_st[i] == 5));
            check_val("pc_we", 32'(pc_we), 32'(exp_st[i] == 5));
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        dmem_ack    = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        exp_cycles += exp_st.size();
        exp_stall  += df + ((kind != 0) ? dd : 0);
        exp_retired++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_retired = 0;
        exp_cycles  = 0;
        exp_stall   = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_retired = 0; exp_cycles = 0; exp_stall = 0;
        rst = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0;

        // Reset state while rst is held
        @(negedge clk);
        check_val("rst_state", 32'(state), 0);
        check_val("rst_imem_req", 32'(imem_req), 0);
        check_val("rst_dmem_req", 32'(dmem_req), 0);
        check_val("rst_halted", 32'(halted), 0);
        check_val("rst_bus_err", 32'(bus_err), 0);
        check_val("rst_retired", 32'(retired_cnt), 0);
        rst = 1'b0;
        #1 check_val("first_imem_req", 32'(imem_req), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // ALU with one wait cycle: states 0,0,1,2,3,5 then back to 0
        run_instr(1, 0, 0);
        #1 check_val("alu_back_fetch", 32'(state), 0);
        check_val("retired_1", 32'(retired_cnt), 1);
        @(negedge clk);
        exp_cycles++;
        // Load whose ack lands exactly on the timeout cycle
        run_instr(0, 1, 3);
        check_val("retired_2", 32'(retired_cnt), 2);
        run_instr(2, 2, 0);
        run_instr(3, 0, 0);
        check_val("bus_err_ack_wins", 32'(bus_err), 0);
        for (int k = 0; k < 11; k++) run_instr(0, 0, 0);
        check_val("retired_15", 32'(retired_cnt), 15);
        run_instr(0, 0, 0);
        check_val("retired_wrap", 32'(retired_cnt), exp_retired % 16);
        check_val("retired_wrap0", 32'(retired_cnt), 0);
`ifdef SEQ_PERF_CNT_EN
        check_val("cycle_cnt", 32'(cycle_cnt), exp_cycles % 16);
        check_val("stall_cnt", 32'(stall_cnt), exp_stall % 16);
`endif

        // is_halt in DECODE
        is_halt = 1'b1;
        imem_ack = 1'b1;
        #1 check_val("halt_ir_we", 32'(ir_we), 1);
        @(negedge clk);
        imem_ack = 1'b0;
        #1 check_val("halt_decode", 32'(state), 1);
        @(negedge clk);
        is_halt = 1'b0;
        #1 check_val("halt_state", 32'(state), 6);
        check_val("halt_halted", 32'(halted), 1);
        check_val("halt_bus_err", 32'(bus_err), 0);
        check_val("halt_retire", 32'(retire), 0);
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check_val("stray_state", 32'(state), 6);
            check_val("stray_ir_we", 32'(ir_we), 0);
            check_val("stray_imem_req", 32'(imem_req), 0);
            check_val("stray_pc_we", 32'(pc_we), 0);
        end
        imem_ack = 1'b0;
        check_val("stray_retired", 32'(retired_cnt), 0);
`ifdef SEQ_PERF_CNT_EN
        check_val("halt_cycle_frozen", 32'(cycle_cnt), (exp_cycles + 2) % 16);
`endif

        // Timeout in FETCH
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1 check_val("to_fetch", 32'(state), 0);
            check_val("to_imem_req", 32'(imem_req), 1);
            @(negedge clk);
        end
        #1 check_val("to_state", 32'(state), 6);
        check_val("to_bus_err", 32'(bus_err), 1);
        check_val("to_halted", 32'(halted), 1);
        check_val("to_imem_req_off", 32'(imem_req), 0);
        check_val("to_retired", 32'(retired_cnt), 0);

        // Async reset in the middle of MEM_ACCESS
        @(negedge clk);
        do_reset();
        run_instr(0, 0, 0);
        check_val("pre_rst_retired", 32'(retired_cnt), 1);
        is_load = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 check_val("mem_dmem_req", 32'(dmem_req), 1);
        check_val("mem_state", 32'(state), 4);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 check_val("arst_dmem_req", 32'(dmem_req), 0);
        check_val("arst_state", 32'(state), 0);
        check_val("arst_retired", 32'(retired_cnt), 0);
        check_val("arst_imem_req", 32'(imem_req), 0);
        @(negedge clk);
        rst = 1'b0;
        is_load = 1'b0;
        dmem_ack = 1'b1;
        exp_retired = 0;
        #1 check_val("late_ack_state", 32'(state), 0);
        check_val("late_ack_imem_req", 32'(imem_req), 1);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1 check_val("late_ack_ignored", 32'(state), 0);
        check_val("late_ack_dmem_req", 32'(dmem_req), 0);
        @(negedge clk);
        run_instr(0, 0, 0);
        check_val("recover_retired", 32'(retired_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
